// File: rtl/gl_fb_writer.sv
// Framebuffer writer: pops pixels from the raster FIFO, clips them, and writes them to memory.
// Also fills the whole framebuffer with a clear colour on request.
module gl_fb_writer #(
   parameter logic [31:0] FB_BASE   = 32'h4000_0000,
   parameter int unsigned FB_WIDTH  = 640,
   parameter int unsigned FB_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [95:0] pixel_fifo_dout,
   input  logic        pixel_fifo_empty,
   output logic        pixel_fifo_rd_en,
   input  logic        clear_start,
   input  logic [31:0] clear_color,
   output logic        clear_done,
   output logic        busy,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic [31:0] pixels_written,
   output logic [31:0] pixels_clipped
);
   localparam logic [31:0] WIDTH32  = 32'(FB_WIDTH);
   localparam logic [31:0] HEIGHT32 = 32'(FB_HEIGHT);
   localparam logic [31:0] LAST_IDX = 32'(FB_WIDTH * FB_HEIGHT - 1);

   typedef enum logic [2:0] {IDLE, POP, LATCH, CHECK, WRITE, CLEAR} state_t;

   state_t      state, state_nxt;
   logic [31:0] x_q, y_q, x_nxt, y_nxt;
   logic [23:0] col_q, col_nxt, clr_q, clr_nxt;
   logic [31:0] idx_q, idx_nxt;
   logic        pend_q, pend_nxt;
   logic        rd_en_nxt, req_nxt, done_nxt, busy_nxt;
   logic [31:0] addr_nxt, wdata_nxt, written_nxt, clipped_nxt;
   logic        ack_c;
   logic        unused_bits;

   assign ack_c       = mem_req && mem_ack;
   assign unused_bits = ^{pixel_fifo_dout[31:24], clear_color[31:24]};

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         x_q              <= '0;
         y_q              <= '0;
         col_q            <= '0;
         clr_q            <= '0;
         idx_q            <= '0;
         pend_q           <= 1'b0;
         pixel_fifo_rd_en <= 1'b0;
         clear_done       <= 1'b0;
         busy             <= 1'b0;
         mem_req          <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         mem_be           <= '0;
         pixels_written   <= '0;
         pixels_clipped   <= '0;
      end else begin
         state            <= state_nxt;
         x_q              <= x_nxt;
         y_q              <= y_nxt;
         col_q            <= col_nxt;
         clr_q            <= clr_nxt;
         idx_q            <= idx_nxt;
         pend_q           <= pend_nxt;
         pixel_fifo_rd_en <= rd_en_nxt;
         clear_done       <= done_nxt;
         busy             <= busy_nxt;
         mem_req          <= req_nxt;
         mem_addr         <= addr_nxt;
         mem_wdata        <= wdata_nxt;
         mem_be           <= {4{req_nxt}};
         pixels_written   <= written_nxt;
         pixels_clipped   <= clipped_nxt;
      end
   end

   // Next state and next output values
   always_comb begin
      state_nxt   = state;
      x_nxt       = x_q;
      y_nxt       = y_q;
      col_nxt     = col_q;
      clr_nxt     = clr_q;
      idx_nxt     = idx_q;
      pend_nxt    = pend_q;
      rd_en_nxt   = 1'b0;
      done_nxt    = 1'b0;
      req_nxt     = mem_req;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;
      written_nxt = pixels_written;
      clipped_nxt = pixels_clipped;

      case (state)
         IDLE: begin
            if (pend_q || clear_start) begin
               state_nxt = CLEAR;
               idx_nxt   = '0;
               clr_nxt   = clear_color[23:0];
               req_nxt   = 1'b1;
               addr_nxt  = FB_BASE;
               wdata_nxt = {8'h00, clear_color[23:0]};
            end else if (!pixel_fifo_empty) begin
               state_nxt = POP;
               rd_en_nxt = 1'b1;
            end
         end
         POP: begin
            if (clear_start) pend_nxt = 1'b1;
            state_nxt = LATCH;
         end
         LATCH: begin
            if (clear_start) pend_nxt = 1'b1;
            x_nxt     = pixel_fifo_dout[95:64];
            y_nxt     = pixel_fifo_dout[63:32];
            col_nxt   = pixel_fifo_dout[23:0];
            state_nxt = CHECK;
         end
         CHECK: begin
            if (clear_start) pend_nxt = 1'b1;
            if (x_q >= WIDTH32 || y_q >= HEIGHT32) begin
               clipped_nxt = pixels_clipped + 32'd1;
               state_nxt   = IDLE;
            end else begin
               addr_nxt  = FB_BASE + ((y_q * WIDTH32 + x_q) << 2);
               wdata_nxt = {8'h00, col_q};
               req_nxt   = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (clear_start) pend_nxt = 1'b1;
            if (ack_c) begin
               req_nxt     = 1'b0;
               written_nxt = pixels_written + 32'd1;
               state_nxt   = IDLE;
            end
         end
         CLEAR: begin
            // Request drops for one cycle between clear beats, as for pixel writes
            if (ack_c) begin
               req_nxt = 1'b0;
               if (idx_q == LAST_IDX) begin
                  done_nxt  = 1'b1;
                  pend_nxt  = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx_q + 32'd1;
               end
            end else if (!mem_req) begin
               req_nxt   = 1'b1;
               addr_nxt  = FB_BASE + (idx_q << 2);
               wdata_nxt = {8'h00, clr_q};
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE) || pend_nxt;
   end
endmodule

// File: tb/tb_gl_fb_writer.sv
// Scoreboard bench for gl_fb_writer: stimulus queues expected memory writes, a monitor checks them.
// Framebuffer height is reduced to 4 lines so full clears stay short.
module tb_gl_fb_writer;
   localparam int unsigned W = 640;
   localparam int unsigned H = 4;
   localparam int unsigned NPIX = W * H;
   localparam logic [31:0] BASE = 32'h4000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [95:0] pixel_fifo_dout = '0;
   logic        pixel_fifo_empty = 1'b1;
   logic        pixel_fifo_rd_en;
   logic        clear_start = 1'b0;
   logic [31:0] clear_color = '0;
   logic        clear_done, busy, mem_req, mem_ack;
   logic [31:0] mem_addr, mem_wdata, pixels_written, pixels_clipped;
   logic [3:0]  mem_be;

   exp_t        exp_q[$];
   logic [95:0] fifo_q[$];
   int          total = 0, bad = 0;
   int          rd_cnt = 0, done_cnt = 0, req_run = 0, last_run = 0;
   int          ack_lat = 0, wait_cnt = 0;
   logic        ack_force = 1'b1, ack_hold = 1'b0, done_exp = 1'b0;
   logic [31:0] prev_addr = '0, prev_data = '0;

   gl_fb_writer #(.FB_BASE(BASE), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
      .clk(clk), .reset(reset),
      .pixel_fifo_dout(pixel_fifo_dout), .pixel_fifo_empty(pixel_fifo_empty),
      .pixel_fifo_rd_en(pixel_fifo_rd_en),
      .clear_start(clear_start), .clear_color(clear_color), .clear_done(clear_done),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack),
      .pixels_written(pixels_written), .pixels_clipped(pixels_clipped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic push_pixel(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
      fifo_q.push_back({x, y, c});
      pixel_fifo_empty = 1'b0;
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic last);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      repeat (2) @(negedge clk);
      while (!(busy == 1'b0 && pixel_fifo_empty && exp_q.size() == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      #3;
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s: timeout after %0d cycles, %0d writes outstanding", name, budget, exp_q.size());
      end
   endtask

   task automatic wait_req(input int budget, input string name);
      int n = 0;
      while (!mem_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s: mem_req never rose within %0d cycles", name, budget);
      end
   endtask

   // FIFO model: dout becomes valid the cycle after the read strobe
   always begin
      logic rd;
      @(negedge clk);
      rd = pixel_fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) pixel_fifo_dout = fifo_q.pop_front();
      pixel_fifo_empty = (fifo_q.size() == 0);
   end

   // Memory responder: ack after ack_lat extra request cycles
   always begin
      @(negedge clk);
      if (ack_force) begin
         mem_ack = 1'b1;
      end else if (mem_req && !ack_hold) begin
         if (wait_cnt >= ack_lat) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
   end

   // Monitor: checks every accepted write against the scoreboard
   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         req_run  = 0;
         done_exp = 1'b0;
      end else begin
         if (pixel_fifo_rd_en) rd_cnt++;
         if (clear_done) done_cnt++;
         if (done_exp) begin
            check("clear_done_pulse", 32'(clear_done), 32'd1);
            done_exp = 1'b0;
         end else if (clear_done) begin
            check("clear_done_unexpected", 32'(clear_done), 32'd0);
         end
         if (mem_req) begin
            check("mem_be", 32'(mem_be), 32'hF);
            if (req_run > 0) begin
               check("addr_stable", mem_addr, prev_addr);
               check("data_stable", mem_wdata, prev_data);
            end
            prev_addr = mem_addr;
            prev_data = mem_wdata;
            req_run++;
            if (mem_ack) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: addr %h data %h with none expected", mem_addr, mem_wdata);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("write_addr", mem_addr, e.addr);
                  check("write_data", mem_wdata, e.data);
                  if (e.last) done_exp = 1'b1;
               end
               last_run = req_run;
               req_run  = 0;
            end
         end else begin
            req_run = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, d0, n;
      mem_ack = 1'b1;
      // Reset with a pixel waiting and ack forced high
      push_pixel(32'd3, 32'd2, 32'hAAFF8040);
      expect_write(32'h4000_140C, 32'h00FF_8040, 1'b0);
      repeat (5) begin
         @(negedge clk);
         #2;
         check("reset_rd_en", 32'(pixel_fifo_rd_en), 32'd0);
         check("reset_mem_req", 32'(mem_req), 32'd0);
         check("reset_busy", 32'(busy), 32'd0);
         check("reset_clear_done", 32'(clear_done), 32'd0);
         check("reset_written", pixels_written, 32'd0);
         check("reset_clipped", pixels_clipped, 32'd0);
      end
      @(negedge clk);
      ack_force = 1'b0;
      ack_lat   = 3;
      reset     = 1'b1;

      // Single pixel, ack three cycles late
      wait_idle(200, "single_pixel");
      check("single_written", pixels_written, 32'd1);
      check("single_clipped", pixels_clipped, 32'd0);
      check("single_req_cycles", 32'(last_run), 32'd4);
      check("single_rd_pulses", 32'(rd_cnt), 32'd1);

      // Clipping at both edges, then in-range boundary pixel
      r0 = rd_cnt;
      push_pixel(32'd640, 32'd0, 32'h0011_2233);
      push_pixel(32'd0, 32'd480, 32'h0044_5566);
      wait_idle(200, "clip");
      check("clip_rd_pulses", 32'(rd_cnt - r0), 32'd2);
      check("clip_clipped", pixels_clipped, 32'd2);
      check("clip_written", pixels_written, 32'd1);
      push_pixel(32'd0, 32'd4, 32'h0077_8899);
      push_pixel(32'd639, 32'd3, 32'h12AB_CDEF);
      expect_write(32'h4000_27FC, 32'h00AB_CDEF, 1'b0);
      wait_idle(200, "boundary");
      check("boundary_clipped", pixels_clipped, 32'd3);
      check("boundary_written", pixels_written, 32'd2);

      // Full clear, zero-wait ack
      ack_lat     = 0;
      clear_color = 32'hAA12_3456;
      for (int i = 0; i < int'(NPIX); i++)
         expect_write(BASE + 32'(i * 4), 32'h0012_3456, i == int'(NPIX) - 1);
      d0 = done_cnt;
      r0 = rd_cnt;
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      wait_idle(20000, "clear");
      check("clear_done_count", 32'(done_cnt - d0), 32'd1);
      check("clear_written", pixels_written, 32'd2);
      check("clear_no_pops", 32'(rd_cnt - r0), 32'd0);

      // Clear requested while a pixel is in WRITE; FIFO still holds another pixel
      ack_lat     = 3;
      clear_color = 32'hFF65_4321;
      push_pixel(32'd1, 32'd0, 32'h1122_3344);
      push_pixel(32'd2, 32'd1, 32'h5566_7788);
      expect_write(32'h4000_0004, 32'h0022_3344, 1'b0);
      for (int i = 0; i < int'(NPIX); i++)
         expect_write(BASE + 32'(i * 4), 32'h0065_4321, i == int'(NPIX) - 1);
      expect_write(32'h4000_0A08, 32'h0066_7788, 1'b0);
      d0 = done_cnt;
      wait_req(100, "pend_req");
      clear_start = 1'b1;
      r0 = rd_cnt;
      @(negedge clk);
      clear_start = 1'b0;
      ack_lat = 0;
      n = 0;
      while (done_cnt == d0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("pend_done_seen", 32'(done_cnt - d0), 32'd1);
      check("pend_no_pop_in_clear", 32'(rd_cnt - r0), 32'd0);
      wait_idle(500, "pend_resume");
      check("pend_pop_resumed", 32'(rd_cnt - r0), 32'd1);
      check("pend_written", pixels_written, 32'd4);

      // Reset while a write is outstanding
      ack_hold = 1'b1;
      push_pixel(32'd5, 32'd1, 32'h00AB_CDEF);
      @(negedge clk);
      wait_req(100, "abort_req");
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_req_drop", 32'(mem_req), 32'd0);
      check("abort_written", pixels_written, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_written_hold", pixels_written, 32'd0);
      ack_hold = 1'b0;
      ack_lat  = 1;
      reset    = 1'b1;
      push_pixel(32'd0, 32'd3, 32'h0010_2030);
      expect_write(32'h4000_1E00, 32'h0010_2030, 1'b0);
      wait_idle(200, "after_abort");
      check("after_abort_written", pixels_written, 32'd1);
      check("after_abort_clipped", pixels_clipped, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
